// File: rtl/local_history_table.sv
// local_history_table: PC-indexed per-branch local history table with a post-reset clear sequence.
// Define LHT_BYPASS_EN so that a same-index lookup and update return the post-update history.
module local_history_table #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 10,
    parameter int HIST_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    input  logic              update_valid,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              update_taken,
    output logic              hist_valid,
    output logic [HIST_W-1:0] hist_out,
    output logic              ready
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;
    logic [IDX_W-1:0] clr_ptr, lk_idx, up_idx, wr_idx;
    logic [HIST_W-1:0] mem [2**IDX_W];
    logic [HIST_W-1:0] up_hist, lk_hist, wr_data;
    logic wr_en, run, unused_pc;
    assign run    = (state == RUN);
    assign ready  = run;
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                         update_pc[PC_W-1:IDX_W+2], update_pc[1:0]};
    assign up_hist = {mem[up_idx][HIST_W-2:0], update_taken};
`ifdef LHT_BYPASS_EN
    assign lk_hist = (update_valid && up_idx == lk_idx) ? up_hist : mem[lk_idx];
`else
    assign lk_hist = mem[lk_idx];
`endif
    // Clear writes and update writes share the single write port; state picks the source.
    always_comb begin
        state_nxt = (!run && &clr_ptr) ? RUN : state;
        wr_en     = !run || update_valid;
        wr_idx    = run ? up_idx : clr_ptr;
        wr_data   = run ? up_hist : '0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            clr_ptr    <= '0;
            hist_valid <= 1'b0;
            hist_out   <= '0;
        end else begin
            state      <= state_nxt;
            if (!run) clr_ptr <= clr_ptr + IDX_W'(1);
            hist_valid <= run && lookup_valid;
            if (run && lookup_valid) hist_out <= lk_hist;
        end
    end
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end
endmodule

// File: tb/tb_local_history_table.sv
// tb_local_history_table: directed checks of clear sequence, history shifting, aliasing and collisions.
module tb_local_history_table;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic        hist_valid;
    logic [9:0]  hist_out;
    logic        ready;
    int checks = 0;
    int errors = 0;
    int n;

    local_history_table dut (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .hist_valid(hist_valid), .hist_out(hist_out), .ready(ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        update_valid = 1'b1;
        update_pc    = pc;
        update_taken = taken;
        step();
        update_valid = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic [9:0] exp);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        step();
        lookup_valid = 1'b0;
        check({tag, "_valid"}, 32'(hist_valid), 32'd1);
        check(tag, 32'(hist_out), 32'(exp));
    endtask

    // Counts edges until ready, driving ignored traffic inside [lo,hi).
    task automatic wait_ready(input int lo, input int hi);
        n = 0;
        while (!ready && n < 2000) begin
            lookup_valid = (n >= lo && n < hi);
            update_valid = (n >= lo && n < hi);
            lookup_pc    = 32'h14;
            update_pc    = 32'h14;
            update_taken = 1'b1;
            step();
            n++;
            if (!ready && hist_valid !== 1'b0) check("init_hist_valid", 32'(hist_valid), 32'd0);
        end
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        check("clear_edges", 32'(n), 32'd1024);
    endtask

    initial begin
        repeat (3) step();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_hist_valid", 32'(hist_valid), 32'd0);
        check("rst_hist_out", 32'(hist_out), 32'd0);
        reset = 1'b0;
        wait_ready(1000, 1010);
        check("ready_after_clear", 32'(ready), 32'd1);
        lookup("first_lookup", 32'h0000_1234, 10'h000);
        step();
        check("idle_valid", 32'(hist_valid), 32'd0);
        check("idle_hold", 32'(hist_out), 32'd0);
        lookup("init_update_ignored", 32'h14, 10'h000);

        upd(32'h40, 1'b1);
        upd(32'h40, 1'b0);
        upd(32'h40, 1'b1);
        upd(32'h40, 1'b1);
        lookup("pattern_1011", 32'h40, 10'h00B);

        repeat (12) upd(32'h100, 1'b1);
        lookup("saturate", 32'h100, 10'h3FF);
        upd(32'h100, 1'b0);
        lookup("shift_zero", 32'h100, 10'h3FE);
        step();
        check("hold_valid", 32'(hist_valid), 32'd0);
        check("hold_value", 32'(hist_out), 32'h3FE);

        upd(32'h1000, 1'b1);
        lookup("alias_idx0", 32'h0, 10'h001);

        upd(32'h80, 1'b1);
        upd(32'h80, 1'b0);
        upd(32'h80, 1'b1);
        lookup("collide_setup", 32'h80, 10'h005);
        update_valid = 1'b1;
        update_pc    = 32'h80;
        update_taken = 1'b0;
`ifdef LHT_BYPASS_EN
        lookup("collide_same_cycle", 32'h80, 10'h00A);
`else
        lookup("collide_same_cycle", 32'h80, 10'h005);
`endif
        update_valid = 1'b0;
        lookup("collide_after", 32'h80, 10'h00A);

        update_valid = 1'b1;
        update_pc    = 32'h100;
        update_taken = 1'b1;
        lookup("diff_idx_lookup", 32'h40, 10'h00B);
        update_valid = 1'b0;
        lookup("diff_idx_update", 32'h100, 10'h3FD);

        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        step();
        lookup_valid = 1'b0;
        check("pre_reset_valid", 32'(hist_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_hist_valid", 32'(hist_valid), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_hist_out", 32'(hist_out), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (500) step();
        check("mid_init_ready", 32'(ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(0, 0);
        lookup("post_reset_cleared", 32'h40, 10'h000);
        lookup("post_reset_saturated_cleared", 32'h100, 10'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
